cdc_handshake_src: RTL and testbench

//  Source-domain half of a two-phase (toggle) req/ack clock-domain crossing.
//  - Accepts one WIDTH-bit word on a valid/ready interface and holds it stable on xfer_data.
//  - Toggles xfer_req to announce the word; the far domain captures it and toggles xfer_ack back.
//  - Synchronises xfer_ack locally with a SYNC_STAGES flop chain and frees the channel for the next word.
//  - Pairs with the multi-flop destination synchroniser used on the SDIO<->AXI boundary.

---
 rtl/cdc_handshake_src.sv | 144 ++++++++++++++
 tb/tb_cdc_handshake_src.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_src.sv
// cdc_handshake_src: source half of a two-phase (toggle) req/ack clock-domain crossing.
// One word is held on xfer_data while xfer_req announces it. The far domain's
// xfer_ack toggle is brought in through a SYNC_STAGES flop chain and frees the
// channel for the next word.
// Optional feature macro: CDC_HS_TIMEOUT_EN. When defined, a WAIT_ACK watchdog aborts
// the transfer after TIMEOUT_CYCLES cycles without an acknowledge.
module cdc_handshake_src #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] xfer_data,
    output logic             xfer_req,
    input  logic             xfer_ack,
    output logic             busy,
    output logic             done_pulse,
    output logic             proto_err,
    output logic             timeout_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       xfer_data_q, xfer_data_d;
    logic                   xfer_req_q, xfer_req_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_sync_dly_q, ack_sync_dly_d;
    logic                   done_pulse_q, done_pulse_d;
    logic                   ack_sync;
    logic                   ack_edge;

    // Parameter legality guard; elaborates to no hardware.
    if (TIMEOUT_CYCLES >= 1 && SYNC_STAGES >= 2 && WIDTH >= 1) begin : g_params_ok
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // Acknowledge synchroniser chain and one-cycle edge detect on its output.
    always_comb begin
        sync_d         = {sync_q[SYNC_STAGES-2:0], xfer_ack};
        ack_sync       = sync_q[SYNC_STAGES-1];
        ack_sync_dly_d = ack_sync;
        ack_edge       = ack_sync ^ ack_sync_dly_q;
    end

    // Handshake FSM: accept in IDLE, hold the word until the ack edge (or watchdog) in WAIT_ACK.
    always_comb begin
        state_d      = state_q;
        xfer_data_d  = xfer_data_q;
        xfer_req_d   = xfer_req_q;
        done_pulse_d = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    xfer_data_d = s_data;
                    xfer_req_d  = ~xfer_req_q;
                    state_d     = WAIT_ACK;
`ifdef CDC_HS_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            WAIT_ACK: begin
                // An ack edge in the watchdog's final cycle still completes normally.
                if (ack_edge) begin
                    state_d      = IDLE;
                    done_pulse_d = 1'b1;
                end
`ifdef CDC_HS_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // Abort without reverting xfer_req; a late ack then shows up as proto_err.
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, payload and synchroniser registers; reset restarts both toggles at 0.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            xfer_data_q    <= '0;
            xfer_req_q     <= 1'b0;
            sync_q         <= '0;
            ack_sync_dly_q <= 1'b0;
            done_pulse_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            xfer_data_q    <= xfer_data_d;
            xfer_req_q     <= xfer_req_d;
            sync_q         <= sync_d;
            ack_sync_dly_q <= ack_sync_dly_d;
            done_pulse_q   <= done_pulse_d;
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    // Watchdog counter and its abort pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign s_ready    = (state_q == IDLE);
    assign busy       = (state_q == WAIT_ACK);
    assign xfer_data  = xfer_data_q;
    assign xfer_req   = xfer_req_q;
    assign done_pulse = done_pulse_q;
    assign proto_err  = (state_q == IDLE) && ack_edge;

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Bench for cdc_handshake_src: directed scenarios plus randomized traffic against a
// transaction-level reference built from edge arithmetic and an event queue.
module tb_cdc_handshake_src;

    localparam int WIDTH = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYCLES = 16;
`ifdef CDC_HS_TIMEOUT_EN
    localparam int MAXD = 20;
`else
    localparam int MAXD = 8;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_req;
    logic             xfer_ack = 1'b0;
    logic             busy;
    logic             done_pulse;
    logic             proto_err;
    logic             timeout_err;

    cdc_handshake_src #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_in(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .xfer_data(xfer_data),
        .xfer_req(xfer_req),
        .xfer_ack(xfer_ack),
        .busy(busy),
        .done_pulse(done_pulse),
        .proto_err(proto_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: transfer in flight, held word, req toggle, edge of accept.
    int               e_idx = 0;
    int               acc_e = 0;
    int               evq[$];
    bit               m_busy = 0;
    bit               m_req = 0;
    logic [WIDTH-1:0] m_data = '0;
    bit               m_done = 0;
    bit               m_to = 0;
    bit               acked_req = 0;
    bit               armed_req = 0;
    int               wait_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e_idx);
        end
    endtask

    // Called at a negedge: check this cycle's outputs, drive inputs, advance the model
    // over the coming posedge, then return at the following negedge.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit tog);
        bit evt;
        bit nd;
        bit nt;
        evt = (evq.size() > 0) && (evq[0] == e_idx);
        check("s_ready", s_ready, !m_busy);
        check("busy", busy, m_busy);
        check("done_pulse", done_pulse, m_done);
        check("timeout_err", timeout_err, m_to);
        check("proto_err", proto_err, !m_busy && evt);
        check("xfer_req", xfer_req, m_req);
        check("xfer_data", xfer_data, m_data);
        s_valid = v;
        s_data  = d;
        if (tog) begin
            xfer_ack = ~xfer_ack;
            // An ack toggled before edge K is acted on at edge K+SYNC_STAGES.
            evq.push_back(e_idx + SYNC_STAGES);
        end
        nd = 0;
        nt = 0;
        if (!m_busy) begin
            if (v) begin
                m_data = d;
                m_req  = ~m_req;
                m_busy = 1;
                acc_e  = e_idx;
            end
        end else begin
            if (evt) begin
                m_busy = 0;
                nd     = 1;
            end
`ifdef CDC_HS_TIMEOUT_EN
            else if (e_idx == acc_e + TIMEOUT_CYCLES) begin
                m_busy = 0;
                nt     = 1;
            end
`endif
        end
        if (evt) void'(evq.pop_front());
        m_done = nd;
        m_to   = nt;
        @(posedge clk);
        e_idx++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    // Far-end responder: acknowledge each new req after a random delay.
    task automatic far_step(output bit tog);
        tog = 0;
        if (m_req != armed_req) begin
            armed_req = m_req;
            wait_cnt  = $urandom_range(0, MAXD);
        end
        if (m_req != acked_req) begin
            if (wait_cnt == 0) begin
                tog       = 1;
                acked_req = m_req;
            end else begin
                wait_cnt--;
            end
        end
    endtask

    task automatic sync_far();
        acked_req = m_req;
        armed_req = m_req;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        xfer_ack = 1'b0;
        s_valid  = 1'b0;
        #1;
        check("rst_xfer_req", xfer_req, 0);
        check("rst_xfer_data", xfer_data, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done_pulse, 0);
        check("rst_proto", proto_err, 0);
        check("rst_timeout", timeout_err, 0);
        m_busy = 0;
        m_req  = 0;
        m_data = '0;
        m_done = 0;
        m_to   = 0;
        evq.delete();
        sync_far();
        @(posedge clk);
        e_idx++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] words[3];
        int idx;
        int cnt;
        int guard;
        bit tog;
        bit v;

        @(negedge clk);
        do_reset();

        // Single word: accept A5 at edge 0, ack toggled before edge 5, done after edge 7.
        cycle(1'b1, 8'hA5, 1'b0);
        idle(4);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("t2_no_early_done", done_pulse, 0);
        cycle(1'b0, '0, 1'b0);
        check("t2_done", done_pulse, 1);
        check("t2_ready", s_ready, 1);
        check("t2_data", xfer_data, 8'hA5);
        sync_far();

        // Spurious ack while idle: one proto_err, then a transfer still needs its own ack.
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (proto_err) cnt++;
            cycle(1'b0, '0, i == 0);
        end
        check("t4_proto_count", cnt, 1);
        cycle(1'b1, 8'h3C, 1'b0);
        idle(10);
        check("t4_still_busy", busy, 1);
        cycle(1'b0, '0, 1'b1);
        idle(3);
        check("t4_completed", s_ready, 1);
        sync_far();

        // Reset in the middle of WAIT_ACK.
        cycle(1'b1, 8'h5A, 1'b0);
        idle(2);
        check("t1_busy_before", busy, 1);
        do_reset();

        // Back-to-back with s_valid held high.
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        idx   = 0;
        cnt   = 0;
        guard = 0;
        while ((idx < 3 || m_busy) && guard < 200) begin
            if (done_pulse) cnt++;
            v = (idx < 3);
            far_step(tog);
            if (v && !m_busy) begin
                cycle(1'b1, words[idx], tog);
                idx++;
            end else begin
                cycle(v, (idx < 3) ? words[idx] : 8'h00, tog);
            end
            guard++;
        end
        if (done_pulse) cnt++;
        check("t3_in_budget", guard < 200, 1);
        check("t3_done_count", cnt, 3);
        check("t3_req_end", xfer_req, 1);
        check("t3_last_word", xfer_data, 8'h33);
        sync_far();

`ifdef CDC_HS_TIMEOUT_EN
        // Timeout abort 16 cycles after entry, then a late ack reports proto_err.
        cycle(1'b1, 8'h77, 1'b0);
        idle(15);
        check("t5_no_early_to", timeout_err, 0);
        check("t5_busy", busy, 1);
        cycle(1'b0, '0, 1'b0);
        check("t5_timeout", timeout_err, 1);
        check("t5_idle", s_ready, 1);
        check("t5_no_done", done_pulse, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (proto_err) cnt++;
            cycle(1'b0, '0, i == 0);
        end
        check("t5_late_proto", cnt, 1);
        sync_far();

        // Ack edge lands in the final watchdog cycle: ack wins.
        cycle(1'b1, 8'h66, 1'b0);
        idle(13);
        cycle(1'b0, '0, 1'b1);
        idle(2);
        check("t6_done", done_pulse, 1);
        check("t6_no_timeout", timeout_err, 0);
        sync_far();
`endif

        // Randomized traffic with delayed acks and occasional spurious toggles.
        for (int i = 0; i < 1500; i++) begin
            far_step(tog);
            if (!tog && !m_busy && m_req == acked_req && evq.size() == 0 &&
                $urandom_range(0, 15) == 0) tog = 1;
            cycle($urandom_range(0, 2) != 0, WIDTH'($urandom), tog);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
